// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } haz_state_t;

  localparam logic [4:0] REG_ZERO            = 5'd0;
  localparam int         MEM_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_det.sv
// Combinational load-use detector: the load in ID/EX writes a register the IF/ID instruction reads.
module haz_load_use_det
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             load_use
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble decode plus a memory wait-state FSM.
// Optional perf counters are built only when PIPE_HAZ_PERF_EN is defined.
//
// state    | meaning
// RUN      | pipeline flowing; branch / load-use hazards resolved here
// MEM_WAIT | data-memory access outstanding; pipeline frozen until ready or timeout
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int REG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_flush
);

  localparam logic [0:0] ST_RUN      = RUN;
  localparam logic [0:0] ST_MEM_WAIT = MEM_WAIT;
  localparam logic [7:0] WAIT_LIMIT  = 8'(MEM_TIMEOUT);

  logic [0:0] state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       holding;
  logic       err_set;
  logic       load_use;

  haz_load_use_det #(.REG_W(REG_W)) u_lu (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_mem_read(ex_mem_read),
    .ex_rt      (ex_rt),
    .load_use   (load_use)
  );

  // wcnt counts wait cycles already spent in MEM_WAIT, so the total hold including
  // the request cycle is capped at MEM_TIMEOUT+1.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    holding   = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          holding   = 1'b1;
          state_nxt = ST_MEM_WAIT;
          wcnt_nxt  = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = ST_RUN;
          wcnt_nxt  = 8'd0;
        end else if (wcnt == WAIT_LIMIT) begin
          err_set   = 1'b1;
          state_nxt = ST_RUN;
          wcnt_nxt  = 8'd0;
        end else begin
          holding  = 1'b1;
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase
  end

  // Branches seen while holding are simply not acted on; ID/EX is frozen so they reappear at release.
  always_comb begin
    pc_load     = 1'b1;
    ifid_load   = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (rst) begin
      pc_load     = 1'b0;
      ifid_load   = 1'b0;
      idex_bubble = 1'b1;
    end else if (holding) begin
      pc_load   = 1'b0;
      ifid_load = 1'b0;
      pipe_hold = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_load   = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_load     = 1'b0;
      ifid_load   = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      wcnt    <= 8'd0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (err_set) mem_err <= 1'b1;
    end
  end

`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_load && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_stall = stall_q;
  assign perf_flush = flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized bench for pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic        pc_load, ifid_load, ifid_flush, idex_bubble, pipe_hold, mem_err;
  logic [31:0] perf_stall, perf_flush;

  int errors = 0;
  int checks = 0;

  // reference model state: access outstanding, hold cycles granted so far, sticky error, perf totals
  bit          m_pending;
  int          m_held;
  bit          m_err;
  logic [31:0] m_stall, m_flush;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(pc_load), .ifid_load(ifid_load), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .mem_err(mem_err),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag);
`ifdef PIPE_HAZ_PERF_EN
    chk({tag, ".perf_stall"}, perf_stall, m_stall);
    chk({tag, ".perf_flush"}, perf_flush, m_flush);
`else
    chk({tag, ".perf_stall"}, perf_stall, 32'd0);
    chk({tag, ".perf_flush"}, perf_flush, 32'd0);
`endif
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_held    = 0;
    m_err     = 0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  // One clock cycle: drive, check mid-cycle, advance model at the edge.
  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic emr, input logic [4:0] ert, input logic br,
                      input logic mreq, input logic mrdy);
    bit lu, hold, abort;
    logic [4:0] e;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = emr; ex_rt = ert;
    ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
    #2;
    lu    = emr && (ert != 0) && (ert == rs || (urt && ert == rt));
    hold  = 0;
    abort = 0;
    if (m_pending) begin
      if (!mrdy) begin
        if (m_held == TO + 1) abort = 1;
        else hold = 1;
      end
    end else if (mreq && !mrdy) begin
      hold = 1;
    end
    // e = {pc_load, ifid_load, ifid_flush, idex_bubble, pipe_hold}
    if (hold)    e = 5'b00001;
    else if (br) e = 5'b10110;
    else if (lu) e = 5'b00010;
    else         e = 5'b11000;
    chk({tag, ".ctl"}, {27'd0, pc_load, ifid_load, ifid_flush, idex_bubble, pipe_hold}, {27'd0, e});
    chk({tag, ".mem_err"}, {31'd0, mem_err}, {31'd0, m_err});
    chk_perf(tag);
    @(posedge clk);
    if (hold) begin
      m_held    = m_pending ? m_held + 1 : 1;
      m_pending = 1;
    end else begin
      m_pending = 0;
      m_held    = 0;
    end
    if (abort) m_err = 1;
    if (!e[4] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (e[2] && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ctl"}, {27'd0, pc_load, ifid_load, ifid_flush, idex_bubble, pipe_hold}, 32'b00010);
    chk({tag, ".mem_err"}, {31'd0, mem_err}, 32'd0);
    chk({tag, ".perf_stall"}, perf_stall, 32'd0);
    chk({tag, ".perf_flush"}, perf_flush, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rt = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    model_reset();
    #2;
    chk_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // load-use on rs: one bubble, then normal flow; ex_rt=0 never stalls
    step("lu_rs",     5'd3, 5'd0, 0, 1, 5'd3, 0, 0, 0);
    step("lu_after",  5'd3, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    step("lu_r0",     5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0);
    step("lu_rt",     5'd1, 5'd7, 1, 1, 5'd7, 0, 0, 0);
    step("lu_rt_nu",  5'd1, 5'd7, 0, 1, 5'd7, 0, 0, 0);
    step("lu_noload", 5'd7, 5'd7, 1, 0, 5'd7, 0, 0, 0);

    // branch beats load-use
    step("br_lu",     5'd3, 5'd0, 0, 1, 5'd3, 1, 0, 0);
    step("br_plain",  5'd2, 5'd0, 0, 0, 5'd0, 1, 0, 0);

    // memory ready three cycles after request
    for (int i = 0; i < 3; i++) step("mw3", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    step("mw3_rel",   5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1);
    step("ready_noreq", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);

    // branch deferred while holding, flushed on the ready cycle
    for (int i = 0; i < 3; i++) step("mw_br", 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0);
    step("mw_br_rel", 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1);

    // timeout: 16 hold cycles, release, sticky error
    for (int i = 0; i < TO + 2; i++) step("tmo", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("tmo_after", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);

    // asynchronous reset in the middle of a wait
    for (int i = 0; i < 4; i++) step("pre_rst", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
